// File: rtl/l1_cache_pkg.sv
// Shared types and width helpers for the set-associative L1 data cache.
package l1_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL
  } state_e;

  // Per-line bookkeeping bits; the tag is attached in the cache top since its
  // width depends on the instance parameters.
  typedef struct packed {
    logic valid;
    logic dirty;
  } line_state_t;

  function automatic int off_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int line_w, input int sets);
    return addr_w - idx_w(sets) - off_w(line_w);
  endfunction

  // A direct-mapped instance still carries a 1-bit way index so ports stay legal.
  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/l1_cache_assoc_plru.sv
// Per-set pseudo-LRU state: reports the replacement way for the looked-up set
// and moves the pointer away from a touched way.
module l1_cache_assoc_plru
  import l1_cache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [idx_w(SETS)-1:0]   lookup_idx,
  output logic [way_w(WAYS)-1:0]   victim,
  input  logic                     touch_en,
  input  logic [idx_w(SETS)-1:0]   touch_idx,
  input  logic [way_w(WAYS)-1:0]   touch_way
);

  if (WAYS == 4) begin : g_tree
    // bit0: 0 -> LRU in ways 0/1, 1 -> LRU in ways 2/3; bit1 picks within 0/1, bit2 within 2/3
    logic [2:0] tree [SETS];
    logic [2:0] cur;

    // Tree update: point the root and the touched pair's leaf away from the access
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < SETS; s++) tree[s] <= '0;
      end else if (touch_en) begin
        tree[touch_idx][0] <= ~touch_way[1];
        if (touch_way[1]) tree[touch_idx][2] <= ~touch_way[0];
        else              tree[touch_idx][1] <= ~touch_way[0];
      end
    end

    assign cur    = tree[lookup_idx];
    assign victim = cur[0] ? {1'b1, cur[2]} : {1'b0, cur[1]};
  end else if (WAYS == 2) begin : g_bit
    // One bit per set naming the least recently used way
    logic lru [SETS];

    // LRU bit update: the other way becomes least recently used
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < SETS; s++) lru[s] <= 1'b0;
      end else if (touch_en) begin
        lru[touch_idx] <= ~touch_way[0];
      end
    end

    assign victim = lru[lookup_idx];
  end else begin : g_none
    assign victim = '0;
  end

endmodule

// File: rtl/l1_cache_assoc.sv
// N-way set-associative write-back, write-allocate L1 data cache with a
// line-wide req/ack memory port. Hits complete in the cycle they are presented.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  IDLE      | lookup; hits complete, a miss latches victim and request
//  WRITEBACK | dirty victim line being written to memory, waiting for ack
//  FILL      | requested line being read from memory, installed on ack
module l1_cache_assoc
  import l1_cache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 8,
  parameter int SETS       = 32,
  parameter int WAYS       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic                         cpu_cs,
  input  logic                         cpu_we,
  input  logic [WORD_W-1:0]            cpu_wdata,
  output logic [WORD_W-1:0]            cpu_rdata,
  output logic                         cpu_stall,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_cs,
  output logic                         mem_we,
  output logic [LINE_WORDS*WORD_W-1:0] mem_wdata,
  input  logic [LINE_WORDS*WORD_W-1:0] mem_rdata,
  input  logic                         mem_ack
);

  localparam int LINE_W = LINE_WORDS * WORD_W;
  localparam int OFF_W  = off_w(LINE_W);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, LINE_W, SETS);
  localparam int WOFF_W = $clog2(LINE_WORDS);
  localparam int WAY_W  = way_w(WAYS);

  typedef struct packed {
    line_state_t      st;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;

  entry_t entry [WAYS][SETS];
  line_t  data  [WAYS][SETS];

  state_e           state;
  logic [TAG_W-1:0] miss_tag;
  logic [IDX_W-1:0] miss_idx;
  logic [WAY_W-1:0] vic_way;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WOFF_W-1:0] req_word;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic              any_inv;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  plru_way;
  logic [WAY_W-1:0]  sel_way;
  entry_t            vic_ent;
  line_t             hit_line;
  logic              acc_hit;
  logic              wr_hit;
  logic              miss;
  logic              fill_done;

  assign req_tag  = cpu_addr[ADDR_W-1 -: TAG_W];
  assign req_idx  = cpu_addr[OFF_W +: IDX_W];
  assign req_word = cpu_addr[2 +: WOFF_W];

  // Tag compare across all ways of the addressed set; at most one can match
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (entry[w][req_idx].st.valid && (entry[w][req_idx].tag == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Lowest-index invalid way is preferred over the PLRU choice
  always_comb begin
    any_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!entry[w][req_idx].st.valid) begin
        any_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign sel_way   = any_inv ? inv_way : plru_way;
  assign vic_ent   = entry[sel_way][req_idx];
  assign hit_line  = data[hit_way][req_idx];
  assign acc_hit   = (state == IDLE) && cpu_cs && hit;
  assign wr_hit    = acc_hit && cpu_we;
  assign miss      = (state == IDLE) && cpu_cs && !hit;
  assign fill_done = (state == FILL) && mem_ack;
  assign cpu_stall = (state != IDLE) || miss;
  assign cpu_rdata = (acc_hit && !cpu_we) ? hit_line[req_word] : '0;

  l1_cache_assoc_plru #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_plru (
    .clk        (clk),
    .rst        (rst),
    .lookup_idx (req_idx),
    .victim     (plru_way),
    .touch_en   (acc_hit || fill_done),
    .touch_idx  (fill_done ? miss_idx : req_idx),
    .touch_way  (fill_done ? vic_way : hit_way)
  );

  // Miss sequencing and the registered memory request
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      miss_tag  <= '0;
      miss_idx  <= '0;
      vic_way   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            // Request address is latched so the CPU may drop cs mid-miss
            miss_tag <= req_tag;
            miss_idx <= req_idx;
            vic_way  <= sel_way;
            mem_cs   <= 1'b1;
            if (vic_ent.st.valid && vic_ent.st.dirty) begin
              state     <= WRITEBACK;
              mem_we    <= 1'b1;
              mem_addr  <= {vic_ent.tag, req_idx, {OFF_W{1'b0}}};
              mem_wdata <= data[sel_way][req_idx];
            end else begin
              state    <= FILL;
              mem_we   <= 1'b0;
              mem_addr <= {req_tag, req_idx, {OFF_W{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            state    <= FILL;
            mem_we   <= 1'b0;
            mem_addr <= {miss_tag, miss_idx, {OFF_W{1'b0}}};
          end
        end
        FILL: begin
          if (mem_ack) begin
            state  <= IDLE;
            mem_cs <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          mem_cs <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  // Valid/dirty/tag: cleared on reset, dirtied by write hits, installed on fill
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++)
          entry[w][s] <= '0;
    end else if (wr_hit) begin
      entry[hit_way][req_idx].st.dirty <= 1'b1;
    end else if (fill_done) begin
      entry[vic_way][miss_idx].st.valid <= 1'b1;
      entry[vic_way][miss_idx].st.dirty <= 1'b0;
      entry[vic_way][miss_idx].tag      <= miss_tag;
    end
  end

  // Line data is unqualified by reset; valid bits gate its use
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      data[hit_way][req_idx][req_word] <= cpu_wdata;
    end else if (fill_done) begin
      data[vic_way][miss_idx] <= mem_rdata;
    end
  end

endmodule
